led_display_scan_ctrl: RTL and testbench

LED_DISPLAY_SCAN_CTRL -- requirements
Module: led_display_scan_ctrl

---
 rtl/led_display_pkg.sv | 38 +++
 rtl/led_display_scan_timer.sv | 27 ++
 rtl/led_display_scan_ctrl.sv | 152 +++++++++++++++
 tb/tb_led_display_scan_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/led_display_pkg.sv
// Shared definitions for the LED panel scan controller: scan state encoding,
// default panel timing and elaboration-time sizing helpers.
package led_display_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_SHIFT_REQ  = 3'd1,
    ST_SHIFT_WAIT = 3'd2,
    ST_BLANK      = 3'd3,
    ST_LATCH      = 3'd4,
    ST_DISPLAY    = 3'd5,
    ST_NEXT       = 3'd6
  } scan_state_e;

  localparam int DEF_NUM_ROW_PIXELS = 32;
  localparam int DEF_NUM_COL_PIXELS = 64;
  localparam int DEF_BIT_DEPTH      = 3;
  localparam int DEF_BASE_ON_CYCLES = 64;
  localparam int DEF_BLANK_CYCLES   = 4;
  localparam int DEF_LATCH_CYCLES   = 2;

  // Width of an index over v items, never below one bit.
  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

  // The timer is loaded with (length - 1), so it must hold the longest
  // interval minus one: the MSB-plane display time dominates in practice.
  function automatic int timer_width(input longint base_on, input int depth,
                                     input longint blank, input longint latch);
    longint m;
    m = base_on << (depth - 1);
    if (blank > m) m = blank;
    if (latch > m) m = latch;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/led_display_scan_timer.sv
// Down-counting interval timer: load (length - 1), expired is high during the
// final cycle of the interval.
module led_display_scan_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             expired
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/led_display_scan_ctrl.sv
// HUB75-style scan controller: per row and bit plane it requests a PHY shift,
// blanks, latches, then lights the LEDs for a binary-weighted on-time.
module led_display_scan_ctrl
  import led_display_pkg::*;
#(
  parameter int NUM_ROW_PIXELS = DEF_NUM_ROW_PIXELS,
  parameter int NUM_COL_PIXELS = DEF_NUM_COL_PIXELS,
  parameter int BIT_DEPTH      = DEF_BIT_DEPTH,
  parameter int BASE_ON_CYCLES = DEF_BASE_ON_CYCLES,
  parameter int BLANK_CYCLES   = DEF_BLANK_CYCLES,
  parameter int LATCH_CYCLES   = DEF_LATCH_CYCLES,
  localparam int NUM_SCAN_ROWS = NUM_ROW_PIXELS / 2,
  localparam int ROW_W         = clog2_min1(NUM_SCAN_ROWS),
  localparam int PLANE_W       = clog2_min1(BIT_DEPTH)
) (
  input  logic               clk_in,
  input  logic               reset_in,
  input  logic               enable_in,
  output logic               shift_req_out,
  input  logic               shift_ack_in,
  input  logic               shift_done_in,
  output logic [ROW_W-1:0]   row_addr_out,
  output logic [PLANE_W-1:0] bit_plane_out,
  output logic               latch_out,
  output logic               blank_out,
  output logic               frame_start_out,
  output logic               frame_done_out
);

  localparam int TMR_W = timer_width(BASE_ON_CYCLES, BIT_DEPTH, BLANK_CYCLES, LATCH_CYCLES);

  localparam logic [ROW_W-1:0]   LAST_ROW   = ROW_W'(NUM_SCAN_ROWS - 1);
  localparam logic [PLANE_W-1:0] LAST_PLANE = PLANE_W'(BIT_DEPTH - 1);
  localparam logic [TMR_W-1:0]   BLANK_LOAD = TMR_W'(BLANK_CYCLES - 1);
  localparam logic [TMR_W-1:0]   LATCH_LOAD = TMR_W'(LATCH_CYCLES - 1);
  localparam logic [TMR_W:0]     BASE_LEN   = (TMR_W + 1)'(BASE_ON_CYCLES);

  if (NUM_ROW_PIXELS < 2 || (NUM_ROW_PIXELS % 2) != 0 || NUM_COL_PIXELS < 1 ||
      BIT_DEPTH < 1 || BASE_ON_CYCLES < 1 || BLANK_CYCLES < 1 || LATCH_CYCLES < 1)
  begin : g_param_check
    $error("led_display_scan_ctrl: invalid parameter set");
  end

  scan_state_e        state_q, state_d;
  logic [ROW_W-1:0]   row_q;
  logic [PLANE_W-1:0] plane_q;
  logic               req_seen_q;
  logic               last_plane, last_row;

  logic               tmr_load;
  logic [TMR_W-1:0]   tmr_load_val;
  logic               tmr_expired;
  logic [TMR_W:0]     disp_len;
  logic [TMR_W-1:0]   disp_load;

  assign last_plane = (plane_q == LAST_PLANE);
  assign last_row   = (row_q == LAST_ROW);

  // One extra bit so the MSB-plane length itself never wraps before the -1.
  assign disp_len  = BASE_LEN << plane_q;
  assign disp_load = TMR_W'(disp_len - (TMR_W + 1)'(1));

  led_display_scan_timer #(
    .CNT_W (TMR_W)
  ) u_timer (
    .clk      (clk_in),
    .rst      (reset_in),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .expired  (tmr_expired)
  );

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q    <= ST_IDLE;
      row_q      <= '0;
      plane_q    <= '0;
      req_seen_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_seen_q <= (state_q == ST_SHIFT_REQ);
      // Addresses move only on leaving NEXT, while the panel is blanked.
      if (state_q == ST_NEXT) begin
        if (last_plane) begin
          plane_q <= '0;
          row_q   <= last_row ? '0 : row_q + ROW_W'(1);
        end else begin
          plane_q <= plane_q + PLANE_W'(1);
        end
      end
    end
  end

  always_comb begin
    state_d         = state_q;
    tmr_load        = 1'b0;
    tmr_load_val    = '0;
    shift_req_out   = 1'b0;
    latch_out       = 1'b0;
    blank_out       = 1'b1;
    frame_start_out = 1'b0;
    frame_done_out  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (enable_in) state_d = ST_SHIFT_REQ;
      end
      ST_SHIFT_REQ: begin
        shift_req_out   = 1'b1;
        frame_start_out = !req_seen_q && (row_q == '0) && (plane_q == '0);
        if (shift_ack_in) state_d = ST_SHIFT_WAIT;
      end
      ST_SHIFT_WAIT: begin
        if (shift_done_in) begin
          state_d      = ST_BLANK;
          tmr_load     = 1'b1;
          tmr_load_val = BLANK_LOAD;
        end
      end
      ST_BLANK: begin
        if (tmr_expired) begin
          state_d      = ST_LATCH;
          tmr_load     = 1'b1;
          tmr_load_val = LATCH_LOAD;
        end
      end
      ST_LATCH: begin
        latch_out = 1'b1;
        if (tmr_expired) begin
          state_d      = ST_DISPLAY;
          tmr_load     = 1'b1;
          tmr_load_val = disp_load;
        end
      end
      ST_DISPLAY: begin
        blank_out = 1'b0;
        if (tmr_expired) state_d = ST_NEXT;
      end
      ST_NEXT: begin
        frame_done_out = last_plane && last_row;
        state_d        = enable_in ? ST_SHIFT_REQ : ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign row_addr_out  = row_q;
  assign bit_plane_out = plane_q;

endmodule

// File: tb/tb_led_display_scan_ctrl.sv
// Directed bench for led_display_scan_ctrl on a 2-row, 2-plane miniature panel.
module tb_led_display_scan_ctrl;

  localparam int BIT_DEPTH      = 2;
  localparam int NUM_ROW_PIXELS = 4;
  localparam int NUM_COL_PIXELS = 8;
  localparam int BASE_ON_CYCLES = 4;
  localparam int BLANK_CYCLES   = 2;
  localparam int LATCH_CYCLES   = 1;

  logic clk;
  logic reset_in, enable_in, shift_ack_in, shift_done_in;
  logic shift_req_out, latch_out, blank_out, frame_start_out, frame_done_out;
  logic [0:0] row_addr_out;
  logic [0:0] bit_plane_out;

  int n_cmp = 0;
  int n_err = 0;
  bit mon_en = 1'b0;
  logic       prev_valid = 1'b0;
  logic       prev_blank = 1'b1;
  logic [0:0] prev_row   = '0;
  logic [0:0] prev_plane = '0;

  led_display_scan_ctrl #(
    .NUM_ROW_PIXELS (NUM_ROW_PIXELS),
    .NUM_COL_PIXELS (NUM_COL_PIXELS),
    .BIT_DEPTH      (BIT_DEPTH),
    .BASE_ON_CYCLES (BASE_ON_CYCLES),
    .BLANK_CYCLES   (BLANK_CYCLES),
    .LATCH_CYCLES   (LATCH_CYCLES)
  ) dut (
    .clk_in          (clk),
    .reset_in        (reset_in),
    .enable_in       (enable_in),
    .shift_req_out   (shift_req_out),
    .shift_ack_in    (shift_ack_in),
    .shift_done_in   (shift_done_in),
    .row_addr_out    (row_addr_out),
    .bit_plane_out   (bit_plane_out),
    .latch_out       (latch_out),
    .blank_out       (blank_out),
    .frame_start_out (frame_start_out),
    .frame_done_out  (frame_done_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Continuous protocol monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (mon_en && !reset_in) begin
      chk("mon_latch_while_lit", {31'd0, latch_out & ~blank_out}, 0);
      chk("mon_req_while_lit", {31'd0, shift_req_out & ~blank_out}, 0);
      if (prev_valid && !prev_blank && !blank_out) begin
        chk("mon_row_stable", {31'd0, row_addr_out}, {31'd0, prev_row});
        chk("mon_plane_stable", {31'd0, bit_plane_out}, {31'd0, prev_plane});
      end
    end
    prev_valid <= mon_en && !reset_in;
    prev_blank <= blank_out;
    prev_row   <= row_addr_out;
    prev_plane <= bit_plane_out;
  end

  // Entered in the first SHIFT_REQ cycle of (r,p); leaves one cycle after NEXT.
  task automatic run_row(input int r, input int p, input int fs, input int fd,
                         input int ack_dly, input int done_dly,
                         input bit stray, input bit drop_en);
    int n;
    chk("req_asserted", {31'd0, shift_req_out}, 1);
    chk("req_row", {31'd0, row_addr_out}, r);
    chk("req_plane", {31'd0, bit_plane_out}, p);
    chk("frame_start", {31'd0, frame_start_out}, fs);
    chk("req_blank", {31'd0, blank_out}, 1);
    for (int i = 0; i < ack_dly; i++) begin
      shift_done_in = stray && (i == 0);
      tick();
      shift_done_in = 1'b0;
      chk("req_held", {31'd0, shift_req_out}, 1);
      chk("req_row_held", {31'd0, row_addr_out}, r);
      chk("req_plane_held", {31'd0, bit_plane_out}, p);
      chk("req_blank_held", {31'd0, blank_out}, 1);
      chk("frame_start_once", {31'd0, frame_start_out}, 0);
    end
    shift_ack_in = 1'b1;
    tick();
    shift_ack_in = 1'b0;
    chk("req_dropped", {31'd0, shift_req_out}, 0);
    for (int i = 0; i < done_dly; i++) begin
      tick();
      chk("wait_blank", {31'd0, blank_out}, 1);
      chk("wait_no_latch", {31'd0, latch_out}, 0);
    end
    shift_done_in = 1'b1;
    tick();
    shift_done_in = 1'b0;
    n = 0;
    while (latch_out !== 1'b1 && n < 100) begin n++; tick(); end
    chk("blank_cycles", n, BLANK_CYCLES);
    n = 0;
    while (latch_out === 1'b1 && n < 100) begin n++; tick(); end
    chk("latch_cycles", n, LATCH_CYCLES);
    chk("display_lit", {31'd0, blank_out}, 0);
    if (drop_en) enable_in = 1'b0;
    n = 0;
    while (blank_out === 1'b0 && n < 1000) begin n++; tick(); end
    chk("display_cycles", n, BASE_ON_CYCLES << p);
    chk("next_frame_done", {31'd0, frame_done_out}, fd);
    chk("next_no_latch", {31'd0, latch_out}, 0);
    chk("next_no_req", {31'd0, shift_req_out}, 0);
    chk("next_row_kept", {31'd0, row_addr_out}, r);
    tick();
  endtask

  initial begin
    int n;
    reset_in = 1'b1; enable_in = 1'b0; shift_ack_in = 1'b0; shift_done_in = 1'b0;
    tick();
    tick();
    chk("rst_req", {31'd0, shift_req_out}, 0);
    chk("rst_latch", {31'd0, latch_out}, 0);
    chk("rst_blank", {31'd0, blank_out}, 1);
    chk("rst_row", {31'd0, row_addr_out}, 0);
    chk("rst_plane", {31'd0, bit_plane_out}, 0);
    chk("rst_fstart", {31'd0, frame_start_out}, 0);
    chk("rst_fdone", {31'd0, frame_done_out}, 0);
    reset_in = 1'b0;
    mon_en = 1'b1;
    tick();
    chk("idle_disabled", {31'd0, shift_req_out}, 0);

    // Full frame, then the start of the next one.
    enable_in = 1'b1;
    tick();
    run_row(0, 0, 1, 0, 0, 3, 1'b0, 1'b0);
    run_row(0, 1, 0, 0, 10, 1, 1'b0, 1'b0);
    run_row(1, 0, 0, 0, 0, 0, 1'b0, 1'b0);
    run_row(1, 1, 0, 1, 1, 2, 1'b0, 1'b0);
    run_row(0, 0, 1, 0, 2, 0, 1'b1, 1'b0);

    // Enable falls during DISPLAY of (r0,p1): row completes, parks in IDLE.
    run_row(0, 1, 0, 0, 0, 0, 1'b0, 1'b1);
    chk("park_req", {31'd0, shift_req_out}, 0);
    chk("park_row", {31'd0, row_addr_out}, 1);
    chk("park_plane", {31'd0, bit_plane_out}, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("park_idle", {31'd0, shift_req_out}, 0);
      chk("park_row_kept", {31'd0, row_addr_out}, 1);
    end
    enable_in = 1'b1;
    tick();
    chk("resume_req", {31'd0, shift_req_out}, 1);
    chk("resume_row", {31'd0, row_addr_out}, 1);
    chk("resume_plane", {31'd0, bit_plane_out}, 0);
    chk("resume_fstart", {31'd0, frame_start_out}, 0);

    // Reset during DISPLAY, followed by a stray done pulse.
    shift_ack_in = 1'b1;
    tick();
    shift_ack_in = 1'b0;
    shift_done_in = 1'b1;
    tick();
    shift_done_in = 1'b0;
    n = 0;
    while (blank_out !== 1'b0 && n < 100) begin n++; tick(); end
    chk("reached_display", {31'd0, blank_out}, 0);
    tick();
    enable_in = 1'b0;
    reset_in = 1'b1;
    tick();
    reset_in = 1'b0;
    chk("rstd_blank", {31'd0, blank_out}, 1);
    chk("rstd_req", {31'd0, shift_req_out}, 0);
    chk("rstd_latch", {31'd0, latch_out}, 0);
    chk("rstd_row", {31'd0, row_addr_out}, 0);
    chk("rstd_plane", {31'd0, bit_plane_out}, 0);
    shift_done_in = 1'b1;
    tick();
    shift_done_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rstd_done_ignored_blank", {31'd0, blank_out}, 1);
      chk("rstd_done_ignored_latch", {31'd0, latch_out}, 0);
    end

    // Reset during SHIFT_WAIT discards the outstanding request.
    enable_in = 1'b1;
    tick();
    chk("rw_req", {31'd0, shift_req_out}, 1);
    chk("rw_fstart", {31'd0, frame_start_out}, 1);
    shift_ack_in = 1'b1;
    tick();
    shift_ack_in = 1'b0;
    chk("rw_wait", {31'd0, shift_req_out}, 0);
    enable_in = 1'b0;
    reset_in = 1'b1;
    tick();
    reset_in = 1'b0;
    shift_done_in = 1'b1;
    tick();
    shift_done_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rw_done_ignored_latch", {31'd0, latch_out}, 0);
      chk("rw_done_ignored_blank", {31'd0, blank_out}, 1);
      chk("rw_done_ignored_req", {31'd0, shift_req_out}, 0);
    end
    enable_in = 1'b1;
    tick();
    run_row(0, 0, 1, 0, 0, 1, 1'b0, 1'b0);

    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
